uart_tx_sched: RTL and testbench
================================

UART_TX_SCHED -- requirements
Module: uart_tx_sched

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, echo FIFO depth; power of two, 2..16.
REQ-002 SHALL have port clk_12mhz  input  1  single clock; all logic on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port rx_valid  input  1  one-cycle pulse from receiver data_ready; push rx_data to echo FIFO.
REQ-005 SHALL have port rx_data  input  8  received byte.
REQ-006 SHALL have port msg_valid  input  1  message requester holds a byte for transmission.
REQ-007 SHALL have port msg_data  input  8  message byte; held stable while msg_valid=1 and msg_ready=0.
REQ-008 SHALL have port msg_ready  output  1  message byte accepted this cycle (handshake = msg_valid & msg_ready).
REQ-009 SHALL have port txd_busy  input  1  transmitter busy.
REQ-010 SHALL have port txd_start  output  1  one-cycle start pulse to transmitter.
REQ-011 SHALL have port txd_data  output  8  byte to transmit; stable from txd_start until busy falls.
REQ-012 SHALL have port fifo_count  output  $clog2(FIFO_DEPTH)+1  echo FIFO occupancy.
REQ-013 SHALL have port overflow  output  1  sticky flag: echo byte dropped.

Function
REQ-014 SHALL share one transmitter between two requesters: echo FIFO (requester E) and message port (requester M).
REQ-015 SHALL use FSM states IDLE, START, WAIT_BUSY, WAIT_DONE.
REQ-016 IDLE: grant only when txd_busy=0 and at least one request (FIFO non-empty or msg_valid=1); else stay.
REQ-017 Arbitration SHALL be round-robin: both pending -> grant the requester not granted last; one pending -> grant it; last-grant register resets to M (so E wins first tie).
REQ-018 On grant to E: pop FIFO head into txd_data register in that cycle; go START.
REQ-019 On grant to M: msg_ready=1 combinationally in that IDLE cycle only; capture msg_data into txd_data; go START.
REQ-020 msg_ready SHALL be 0 in all other states and cycles.
REQ-021 START: txd_start=1 for exactly one cycle; go WAIT_BUSY.
REQ-022 WAIT_BUSY: stay until txd_busy=1, then go WAIT_DONE.
REQ-023 WAIT_DONE: stay until txd_busy=0, then go IDLE.
REQ-024 Latency: rx_valid at cycle N with idle scheduler and empty FIFO -> txd_start=1 at cycle N+2.
REQ-025 FIFO push on rx_valid SHALL occur in any state; FIFO is circular, pointers wrap at FIFO_DEPTH.
REQ-026 Push when full with simultaneous pop SHALL be accepted; count unchanged.
REQ-027 Push when full without pop SHALL drop the byte, leave FIFO unchanged and set overflow=1.
REQ-028 Pop SHALL never occur when empty; fifo_count SHALL never exceed FIFO_DEPTH.
REQ-029 overflow SHALL clear only on reset.

Reset
REQ-030 On reset=1 at a clock edge: state IDLE, FIFO empty (pointers 0, fifo_count=0), overflow=0, txd_start=0, txd_data=8'h00, last-grant=M.
REQ-031 Reset mid-transfer SHALL abandon the transfer and any captured byte; no txd_start until a new request after reset deasserts.
REQ-032 msg_ready SHALL be 0 while reset=1.

Verification
REQ-033 Echo: rx_valid with 8'hA5 at cycle N, busy model rises at N+3 for 10 cycles -> txd_start at N+2 with txd_data=8'hA5, one pulse only, FSM back to IDLE after busy falls.
REQ-034 Arbitration: FIFO holds 8'h11,8'h22 and msg_valid=1 with 8'h80 held -> transmit order 8'h11, 8'h80, 8'h22; msg_ready single pulse in the second IDLE grant.
REQ-035 Overflow: FIFO_DEPTH=4, busy held high, 5 rx_valid pulses 8'h01..8'h05 -> fifo_count=4, overflow=1, later output order 8'h01..8'h04, 8'h05 never sent.
REQ-036 Full push+pop: FIFO full, rx_valid coincides with E grant -> count stays 4, new byte transmitted last, overflow=0.
REQ-037 Reset mid-transfer: reset in WAIT_DONE with 2 bytes queued -> next cycle fifo_count=0, txd_start=0, txd_data=8'h00; no transmission until new rx_valid.
REQ-038 Busy held high in IDLE with msg_valid=1 -> no grant, msg_ready=0, txd_start=0 until busy falls.

Source files
------------

// File: rtl/uart_tx_sched.sv
// uart_tx_sched: round-robin sharing of one UART transmitter between an echo FIFO and a message port.
module uart_tx_sched #(
   parameter int FIFO_DEPTH = 4
) (
   input  logic                          clk_12mhz,
   input  logic                          reset,
   input  logic                          rx_valid,
   input  logic [7:0]                    rx_data,
   input  logic                          msg_valid,
   input  logic [7:0]                    msg_data,
   output logic                          msg_ready,
   input  logic                          txd_busy,
   output logic                          txd_start,
   output logic [7:0]                    txd_data,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic                          overflow
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   typedef enum logic [1:0] {IDLE, START, WAIT_BUSY, WAIT_DONE} state_t;
   state_t          state_q, state_d;
   logic [7:0]      mem_q [FIFO_DEPTH];
   logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]   count_q, count_d;
   logic [7:0]      txd_data_q, txd_data_d;
   logic            txd_start_q, txd_start_d;
   logic            overflow_q, overflow_d;
   logic            last_m_q, last_m_d;
   logic            idle_free, req_e, full, grant_e, grant_m, push, pop;
   always_comb begin
      idle_free   = (state_q == IDLE) && !txd_busy;
      req_e       = count_q != '0;
      full        = count_q == CW'(FIFO_DEPTH);
      // last_m_q=1 means M was granted last, so E wins a tie
      grant_e     = idle_free && req_e && (!msg_valid || last_m_q);
      grant_m     = idle_free && msg_valid && (!req_e || !last_m_q);
      pop         = grant_e;
      push        = rx_valid && (!full || pop);
      state_d     = (state_q == IDLE)      ? ((grant_e || grant_m) ? START : IDLE) :
                    (state_q == START)     ? WAIT_BUSY :
                    (state_q == WAIT_BUSY) ? (txd_busy ? WAIT_DONE : WAIT_BUSY) :
                                             (txd_busy ? WAIT_DONE : IDLE);
      wr_ptr_d    = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_d    = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
      count_d     = count_q + CW'(push) - CW'(pop);
      txd_data_d  = grant_e ? mem_q[rd_ptr_q] : grant_m ? msg_data : txd_data_q;
      txd_start_d = grant_e || grant_m;
      last_m_d    = grant_m ? 1'b1 : grant_e ? 1'b0 : last_m_q;
      overflow_d  = overflow_q || (rx_valid && full && !pop);
   end
   always_ff @(posedge clk_12mhz) begin
      if (reset) begin
         state_q     <= IDLE;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         txd_data_q  <= 8'h00;
         txd_start_q <= 1'b0;
         overflow_q  <= 1'b0;
         last_m_q    <= 1'b1;
      end else begin
         state_q     <= state_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         txd_data_q  <= txd_data_d;
         txd_start_q <= txd_start_d;
         overflow_q  <= overflow_d;
         last_m_q    <= last_m_d;
      end
   end
   always_ff @(posedge clk_12mhz) begin
      if (push) mem_q[wr_ptr_q] <= rx_data;
   end
   assign msg_ready  = grant_m && !reset;
   assign txd_start  = txd_start_q;
   assign txd_data   = txd_data_q;
   assign fifo_count = count_q;
   assign overflow   = overflow_q;
endmodule

// File: tb/tb_uart_tx_sched.sv
// tb_uart_tx_sched: scoreboard bench; expected bytes queued at stimulus, checked on each txd_start.
module tb_uart_tx_sched;
   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       rx_valid = 1'b0;
   logic [7:0] rx_data = 8'h00;
   logic       msg_valid = 1'b0;
   logic [7:0] msg_data = 8'h00;
   logic       msg_ready;
   logic       txd_busy;
   logic       txd_start;
   logic [7:0] txd_data;
   logic [2:0] fifo_count;
   logic       overflow;
   logic       force_busy = 1'b0;
   int         bcnt = 0;
   logic [7:0] sbq [$];
   int         n_chk = 0;
   int         n_fail = 0;
   int         mr_cnt = 0;
   int         mr_base;
   logic       got;
   uart_tx_sched #(.FIFO_DEPTH(4)) dut (
      .clk_12mhz(clk), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data),
      .msg_valid(msg_valid), .msg_data(msg_data), .msg_ready(msg_ready),
      .txd_busy(txd_busy), .txd_start(txd_start), .txd_data(txd_data),
      .fifo_count(fifo_count), .overflow(overflow)
   );
   always #5 clk = ~clk;
   // transmitter model: busy for 10 cycles starting the cycle after txd_start
   assign txd_busy = force_busy || (bcnt != 0);
   always @(posedge clk) bcnt <= txd_start ? 10 : (bcnt != 0 ? bcnt - 1 : 0);
   function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endfunction
   always @(negedge clk) begin
      if (msg_ready) mr_cnt++;
      if (txd_start) begin
         if (sbq.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_start: got data %0h expected no start", txd_data);
         end else chk("txd_data", txd_data, sbq.pop_front());
      end
   end
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic rx(input logic [7:0] d);
      rx_valid = 1'b1;
      rx_data  = d;
      tick();
      rx_valid = 1'b0;
   endtask
   initial begin
      msg_valid = 1'b1;
      msg_data  = 8'h77;
      tick();
      tick();
      @(negedge clk);
      chk("rst_msg_ready", msg_ready, 0);
      chk("rst_count", fifo_count, 0);
      chk("rst_overflow", overflow, 0);
      chk("rst_start", txd_start, 0);
      chk("rst_data", txd_data, 8'h00);
      tick();
      reset = 1'b0;
      msg_valid = 1'b0;
      // echo latency: push at N, start at N+2
      sbq.push_back(8'hA5);
      rx(8'hA5);
      @(negedge clk);
      chk("lat_n1_start", txd_start, 0);
      chk("lat_n1_count", fifo_count, 1);
      tick();
      @(negedge clk);
      chk("lat_n2_start", txd_start, 1);
      chk("lat_n2_data", txd_data, 8'hA5);
      repeat (16) tick();
      chk("echo_drained", sbq.size(), 0);
      chk("echo_count", fifo_count, 0);
      // overflow
      force_busy = 1'b1;
      for (int i = 1; i <= 5; i++) rx(8'(i));
      for (int i = 1; i <= 4; i++) sbq.push_back(8'(i));
      @(negedge clk);
      chk("ovf_count", fifo_count, 4);
      chk("ovf_flag", overflow, 1);
      tick();
      force_busy = 1'b0;
      repeat (70) tick();
      chk("ovf_drained", sbq.size(), 0);
      chk("ovf_count_end", fifo_count, 0);
      chk("ovf_sticky", overflow, 1);
      // arbitration, busy blocks grants in IDLE
      reset = 1'b1;
      tick();
      reset = 1'b0;
      @(negedge clk);
      chk("rst2_overflow", overflow, 0);
      tick();
      force_busy = 1'b1;
      rx(8'h11);
      rx(8'h22);
      msg_valid = 1'b1;
      msg_data  = 8'h80;
      sbq.push_back(8'h11);
      sbq.push_back(8'h80);
      sbq.push_back(8'h22);
      mr_base = mr_cnt;
      repeat (3) begin
         @(negedge clk);
         chk("busy_msg_ready", msg_ready, 0);
         chk("busy_start", txd_start, 0);
         tick();
      end
      force_busy = 1'b0;
      got = 1'b0;
      for (int i = 0; i < 100 && !got; i++) begin
         @(negedge clk);
         if (msg_ready) got = 1'b1;
      end
      chk("arb_msg_ready_seen", got, 1);
      tick();
      msg_valid = 1'b0;
      repeat (40) tick();
      chk("arb_msg_ready_pulses", mr_cnt - mr_base, 1);
      chk("arb_drained", sbq.size(), 0);
      // full FIFO with push coinciding with pop
      force_busy = 1'b1;
      for (int i = 0; i < 4; i++) rx(8'h31 + 8'(i));
      for (int i = 0; i < 5; i++) sbq.push_back(8'h31 + 8'(i));
      @(negedge clk);
      chk("fp_full", fifo_count, 4);
      tick();
      force_busy = 1'b0;
      rx_valid = 1'b1;
      rx_data  = 8'h35;
      tick();
      rx_valid = 1'b0;
      @(negedge clk);
      chk("fp_count", fifo_count, 4);
      chk("fp_overflow", overflow, 0);
      chk("fp_start", txd_start, 1);
      repeat (80) tick();
      chk("fp_drained", sbq.size(), 0);
      chk("fp_count_end", fifo_count, 0);
      // reset mid-transfer
      force_busy = 1'b1;
      rx(8'h41);
      rx(8'h42);
      rx(8'h43);
      sbq.push_back(8'h41);
      force_busy = 1'b0;
      got = 1'b0;
      for (int i = 0; i < 50 && !got; i++) begin
         @(negedge clk);
         if (txd_start) got = 1'b1;
      end
      chk("mid_start_seen", got, 1);
      repeat (3) tick();
      @(negedge clk);
      chk("mid_count", fifo_count, 2);
      chk("mid_busy", txd_busy, 1);
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      @(negedge clk);
      chk("mid_rst_count", fifo_count, 0);
      chk("mid_rst_start", txd_start, 0);
      chk("mid_rst_data", txd_data, 8'h00);
      repeat (30) tick();
      chk("mid_quiet", sbq.size(), 0);
      sbq.push_back(8'h55);
      rx(8'h55);
      repeat (20) tick();
      chk("mid_new_sent", sbq.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
